// File: rtl/ddu_ctrl.sv
// ddu_ctrl: debug unit controller -- button conditioning, address stepping, single-step FSM, 7-seg scan (optional watchdog via DDU_STEP_WATCHDOG_EN)
module ddu_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cont,
    input  logic        step,
    input  logic        inc,
    input  logic        dec,
    input  logic        mem,
    input  logic [3:0]  state,
    input  logic [31:0] currentAddress,
    input  logic [31:0] DDU_mem_data,
    input  logic [31:0] DDU_reg_data,
    output logic        run,
    output logic [31:0] DDU_addr,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        step_err
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LEAVE, FINISH} fsm_t;

    logic [3:0]    r_sync1, r_sync2;
    logic [2:0]    r_db, r_pulse;
    logic [DW-1:0] r_cnt [3];
    logic [31:0]   r_addr;
    logic [2:0]    r_idx;
    logic [SW-1:0] r_div;
    fsm_t          r_fsm, w_fsm_nxt;
    logic          w_step_p, w_cont, w_wd_exp, w_unused;
    logic [31:0]   w_data;
    logic [3:0]    w_nib;
    logic [6:0]    w_glyph;

    assign w_step_p = r_pulse[0];
    assign w_cont   = r_sync2[3];
    assign w_unused = &{1'b0, currentAddress[31:10], currentAddress[1:0]};

    // two-flop synchronizers, bit order {cont, dec, inc, step}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {cont, dec, inc, step};
            r_sync2 <= r_sync1;
        end
    end

    // debounce step/inc/dec and emit one pulse on each accepted rising level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db    <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i]   <= '0;
                    r_pulse[i] <= 1'b0;
                end else if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]    <= r_sync2[i];
                    r_cnt[i]   <= '0;
                    r_pulse[i] <= r_sync2[i];
                end else begin
                    r_cnt[i]   <= r_cnt[i] + DW'(1);
                    r_pulse[i] <= 1'b0;
                end
            end
        end
    end

    // debug address: inc/dec pulses, simultaneous pulses cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_addr <= '0;
        else if (r_pulse[1] && !r_pulse[2])
            r_addr <= r_addr + 32'd1;
        else if (r_pulse[2] && !r_pulse[1])
            r_addr <= r_addr - 32'd1;
    end

`ifdef DDU_STEP_WATCHDOG_EN
    logic [7:0] r_wd;
    logic       r_err;

    assign w_wd_exp = (r_fsm != IDLE) && (r_wd == 8'hFF);
    assign step_err = r_err;

    // watchdog counts cycles spent outside IDLE; expiry is sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd  <= (r_fsm == IDLE) ? 8'd0 : r_wd + 8'd1;
            r_err <= r_err | w_wd_exp;
        end
    end
`else
    assign w_wd_exp = 1'b0;
    assign step_err = 1'b0;
`endif

    // step FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_fsm <= IDLE;
        else
            r_fsm <= w_fsm_nxt;
    end

    // step FSM next state: leave fetch, finish the instruction, stop at next fetch
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (w_step_p && !w_cont) w_fsm_nxt = LEAVE;
            LEAVE:   if (state != 4'd0) w_fsm_nxt = FINISH;
            FINISH:  if (state == 4'd0) w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
        if (w_wd_exp) w_fsm_nxt = IDLE;
    end

    assign run = w_cont || (r_fsm == LEAVE) || ((r_fsm == FINISH) && (state != 4'd0));

    // digit scan: prescaler then 3-bit digit index wrapping 7->0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == SW'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_div <= r_div + SW'(1);
        end
    end

    assign w_data = mem ? DDU_mem_data : DDU_reg_data;
    assign w_nib  = w_data[{r_idx, 2'b00} +: 4];

    // active-low hex glyph, bit order g..a
    always_comb begin
        w_glyph = 7'h7F;
        case (w_nib)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            default: w_glyph = 7'h0E;
        endcase
    end

    assign seg      = {1'b1, w_glyph};
    assign an       = ~(8'd1 << r_idx);
    assign DDU_addr = r_addr;
    assign led      = {currentAddress[9:2], r_addr[7:0]};
endmodule

// File: tb/tb_ddu_ctrl.sv
// tb_ddu_ctrl: directed self-checking bench for ddu_ctrl with a tiny 4-state CPU model
module tb_ddu_ctrl;
    logic        clk = 1'b0;
    logic        rst, cont, step, inc, dec, mem;
    logic [3:0]  state = 4'd0;
    logic [31:0] cur_addr, mem_data, reg_data;
    logic        run, step_err;
    logic [31:0] ddu_addr;
    logic [15:0] led;
    logic [7:0]  an, seg;

    logic cpu_en = 1'b0, cpu_clr = 1'b1, run_s = 1'b0;
    int   instr = 0, run_cycles = 0;
    int   n_chk = 0, n_fail = 0;
    int   i0, r0;

    logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg_tab [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    ddu_ctrl dut (
        .clk(clk), .rst(rst), .cont(cont), .step(step), .inc(inc), .dec(dec), .mem(mem),
        .state(state), .currentAddress(cur_addr), .DDU_mem_data(mem_data), .DDU_reg_data(reg_data),
        .run(run), .DDU_addr(ddu_addr), .led(led), .an(an), .seg(seg), .step_err(step_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        run_s = run;
        if (cpu_en && run) run_cycles++;
    end

    always @(posedge clk) begin
        #1;
        if (cpu_clr)
            state = 4'd0;
        else if (cpu_en && run_s) begin
            state = (state == 4'd3) ? 4'd0 : state + 4'd1;
            if (state == 4'd0) instr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [2:0] m, input int n);
        {step, dec, inc} = m;
        repeat (n) @(negedge clk);
        {step, dec, inc} = 3'b000;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; cont = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0; mem = 1'b1;
        cur_addr = 32'h0000_03FC; mem_data = 32'h1234_ABCD; reg_data = 32'h0000_0005;
        repeat (3) @(negedge clk);
        check("rst_run", run, 0);
        check("rst_addr", ddu_addr, 0);
        check("rst_an", an, 8'hFE);
        check("rst_seg", seg, 8'hA1);
        check("rst_err", step_err, 0);
        check("rst_led", led, 16'hFF00);
        cpu_clr = 1'b0;
        rst = 1'b1;
        for (int d = 0; d < 8; d++) begin
            check($sformatf("scan_an%0d", d), an, an_tab[d]);
            check($sformatf("scan_seg%0d", d), seg, seg_tab[d]);
            repeat (4) @(negedge clk);
        end
        check("scan_wrap", an, 8'hFE);
        mem = 1'b0;
        #1 check("sel_reg", seg, 8'h92);

        repeat (3) press(3'b001, 10);
        check("inc3_addr", ddu_addr, 3);
        check("inc3_led", led, 16'hFF03);
        repeat (3) press(3'b010, 10);
        check("dec_to0", ddu_addr, 0);
        press(3'b010, 10);
        check("dec_wrap", ddu_addr, 32'hFFFF_FFFF);
        check("dec_led", led[7:0], 8'hFF);
        press(3'b001, 1);
        check("glitch1", ddu_addr, 32'hFFFF_FFFF);
        press(3'b001, 3);
        check("glitch3", ddu_addr, 32'hFFFF_FFFF);
        press(3'b011, 10);
        check("both", ddu_addr, 32'hFFFF_FFFF);
        press(3'b001, 10);
        check("inc_wrap", ddu_addr, 0);

        cpu_en = 1'b1;
        i0 = instr; r0 = run_cycles;
        step = 1'b1;
        for (int k = 0; k < 60 && instr == i0; k++) @(negedge clk);
        check("step_one", instr - i0, 1);
        check("step_halt", run, 0);
        check("step_state", state, 0);
        repeat (20) @(negedge clk);
        check("step_hold", instr - i0, 1);
        check("step_runcyc", run_cycles - r0, 4);
        step = 1'b0;
        repeat (10) @(negedge clk);

        cpu_en = 1'b0;
        cont = 1'b1;
        @(posedge clk); #1 check("cont_1clk", run, 0);
        @(posedge clk); #1 check("cont_2clk", run, 1);
        press(3'b100, 10);
        press(3'b100, 10);
        cont = 1'b0;
        repeat (5) @(negedge clk);
        check("cont_step_ign", run, 0);

        cpu_en = 1'b1;
        step = 1'b1;
        for (int k = 0; k < 40 && !run; k++) @(negedge clk);
        check("mid_run", run, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("mid_rst_run", run, 0);
        check("mid_rst_addr", ddu_addr, 0);
        cpu_en = 1'b0; cpu_clr = 1'b1; step = 1'b0;
        repeat (5) @(negedge clk);
        cpu_clr = 1'b0;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("no_resume", run, 0);

        press(3'b100, 10);
        check("wd_start", run, 1);
        repeat (300) @(negedge clk);
`ifdef DDU_STEP_WATCHDOG_EN
        check("wd_run", run, 0);
        check("wd_err", step_err, 1);
        repeat (10) @(negedge clk);
        check("wd_err_hold", step_err, 1);
`else
        check("nowd_run", run, 1);
        check("nowd_err", step_err, 0);
`endif
        rst = 1'b0;
        #1 check("final_rst_run", run, 0);
        check("final_rst_err", step_err, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ddu_ctrl.md
DDU_CTRL -- requirements
Module: ddu_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples required before a button level is accepted.
REQ-002 Parameter SCAN_DIV, default 4: clocks per 7-segment digit slot.
REQ-003 Port clk, input, 1: single clock; all state advances on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port cont, input, 1: level switch; 1 = free-run CPU.
REQ-006 Port step, input, 1: raw button; single-step one instruction.
REQ-007 Port inc, input, 1: raw button; DDU_addr + 1.
REQ-008 Port dec, input, 1: raw button; DDU_addr - 1.
REQ-009 Port mem, input, 1: display select; 1 = DDU_mem_data, 0 = DDU_reg_data.
REQ-010 Port state, input, 4: CPU FSM state; 0 = instruction fetch.
REQ-011 Port currentAddress, input, 32: CPU PC.
REQ-012 Port DDU_mem_data, input, 32: memory word at DDU_addr.
REQ-013 Port DDU_reg_data, input, 32: register at DDU_addr[4:0].
REQ-014 Port run, output, 1: CPU clock enable.
REQ-015 Port DDU_addr, output, 32: debug word address.
REQ-016 Port led, output, 16: {currentAddress[9:2], DDU_addr[7:0]}.
REQ-017 Port an, output, 8: digit enables, active-low, one-hot.
REQ-018 Port seg, output, 8: {dp, g..a}, active-low.
REQ-019 Port step_err, output, 1: sticky step-timeout flag.

Function
REQ-020 step/inc/dec/cont SHALL each pass a 2-flop synchronizer; step/inc/dec levels SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-021 A debounced 0->1 transition SHALL produce exactly one 1-cycle pulse; holding the button SHALL produce no further pulses.
REQ-022 inc pulse: DDU_addr+1 mod 2^32; dec pulse: DDU_addr-1 mod 2^32 (0 -> FFFFFFFF); both pulses in the same cycle: no change.
REQ-023 Step FSM states IDLE, LEAVE, FINISH; IDLE->LEAVE on step pulse when synchronized cont=0; LEAVE->FINISH when state!=0; FINISH->IDLE when state==0.
REQ-024 run SHALL be combinational: cont_sync | (FSM==LEAVE) | (FSM==FINISH & state!=0), so the CPU halts at fetch after exactly one instruction.
REQ-025 Step pulses outside IDLE, or while cont_sync=1, SHALL be ignored.
REQ-026 Scan counter SHALL advance digit index 0..7 every SCAN_DIV clocks, wrapping 7->0; an[i]=0 iff index==i.
REQ-027 Digit i SHALL show hex nibble [4i+3:4i] of the selected data (0-F standard glyphs); seg[7] (dp) SHALL be 1; data select SHALL be combinational from mem.

Reset
REQ-028 rst=0 SHALL immediately clear: synchronizers, debouncers, FSM to IDLE, DDU_addr=0, scan index 0, prescaler 0, step_err=0.
REQ-029 During reset run=0, an=8'hFE, seg shows nibble 0 of the selected data.
REQ-030 Reset asserted mid-step SHALL drop run in the same instant; no step SHALL resume after release.

Configuration
REQ-031 Macro DDU_STEP_WATCHDOG_EN defined: 8-bit counter runs while FSM!=IDLE; on reaching 255 the FSM SHALL return to IDLE, run SHALL drop, and step_err SHALL set and hold until reset.
REQ-032 Macro undefined: no watchdog logic; step_err SHALL be constant 0; FSM waits indefinitely.

Verification
REQ-033 Reset released, inc pressed 3 times (each held > DEBOUNCE_CYCLES+2) -> DDU_addr=3, led[7:0]=8'h03.
REQ-034 From DDU_addr=0, one dec press -> DDU_addr=32'hFFFFFFFF; 1-cycle glitches on inc -> no change.
REQ-035 cont=0, state model 0->1->2->3->0, step press -> run high from LEAVE entry, low in the first cycle state==0 returns; exactly one instruction; holding step -> no second.
REQ-036 cont=1 -> run=1 two clocks after cont rises; step presses -> no FSM change.
REQ-037 mem=1, DDU_mem_data=32'h1234ABCD, SCAN_DIV=4 -> an cycles FE,FD,...,7F every 4 clocks; seg digits D,C,B,A,4,3,2,1.
REQ-038 DDU_STEP_WATCHDOG_EN defined, state held 0 after step -> run drops after 255 cycles, step_err=1 until rst=0.
